// File: rtl/gate_test_sequencer.sv
// Clocked exhaustive stimulus/check sequencer for small combinational gates.
// Walks every input vector, holds it SETTLE cycles, then compares dut_out to EXPECT.
module gate_test_sequencer #(
  parameter int                      N_IN   = 3,
  parameter int                      SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]    EXPECT = 8'h7F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec
);

  localparam logic [N_IN-1:0] LAST    = '1;
  localparam logic [N_IN:0]   ERR_MAX = (N_IN+1)'(1 << N_IN);
  localparam logic [3:0]      SET_M1  = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [N_IN-1:0] dut_in_d, fail_vec_d;
  logic [N_IN:0]   err_cnt_d;
  logic            busy_d, done_d, pass_d, mis;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in;
    fail_vec_d = fail_vec;
    err_cnt_d  = err_cnt;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    mis        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dut_in_d   = '0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = APPLY;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SET_M1) state_d = CHECK;
      end
      CHECK: begin
        mis = (dut_out != EXPECT[dut_in]);
        if (mis && err_cnt != ERR_MAX) err_cnt_d = err_cnt + 1'b1;
        if (mis && err_cnt == '0) fail_vec_d = dut_in;
        if (dut_in != LAST) begin
          dut_in_d = dut_in + 1'b1;
          cnt_d    = '0;
          state_d  = APPLY;
        end else begin
          // pass must see the final vector's mismatch, so use the next count
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dut_in   <= '0;
      fail_vec <= '0;
      err_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dut_in   <= dut_in_d;
      fail_vec <= fail_vec_d;
      err_cnt  <= err_cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench: default 3-input NAND sequencer plus a 2-input, SETTLE=1 instance.
// The gate under test is a per-vector response table; expectations come from a table-walk model.
module tb_gate_test_sequencer;

  localparam logic [7:0] EXP  = 8'h7F;
  localparam logic [3:0] EXP2 = 4'b0111;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic [7:0] resp  = EXP;
  logic [3:0] resp2 = EXP2;
  logic       dut_out, dut_out2;
  logic [2:0] dut_in, fail_vec;
  logic [3:0] err_cnt;
  logic       busy, done, pass;
  logic [1:0] dut_in2, fail_vec2;
  logic [2:0] err_cnt2;
  logic       busy2, done2, pass2;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  assign dut_out  = resp[dut_in];
  assign dut_out2 = resp2[dut_in2];

  gate_test_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  gate_test_sequencer #(.N_IN(2), .SETTLE(1), .EXPECT(EXP2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_out(dut_out2),
    .dut_in(dut_in2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .fail_vec(fail_vec2)
  );

  // Reference: mismatches are simply the vectors where response differs from truth table.
  function automatic void model(input logic [7:0] e, input logic [7:0] r, input int nv,
                                output int ec, output int fv);
    ec = 0; fv = 0;
    for (int i = 0; i < nv; i++)
      if (r[i] !== e[i]) begin
        if (ec == 0) fv = i;
        ec++;
      end
  endfunction

  // Runs one sweep on the default instance and reports what it saw; no judging here.
  task automatic sweep(input int restart_at, input int extra, output int lat, output int ndone,
                       output int seq_bad, output logic [3:0] ec, output logic [2:0] fv,
                       output logic ps, output logic ps_mid);
    lat = -1; ndone = 0; seq_bad = 0; ec = 'x; fv = 'x; ps = 1'bx; ps_mid = 1'bx;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (busy !== 1'b1 || dut_in !== 3'd0 || err_cnt !== 4'd0 || fail_vec !== 3'd0) seq_bad++;
    for (int n = 1; n <= 24 + extra; n++) begin
      @(posedge clk); #1;
      if (n < 24) begin
        if (dut_in !== 3'(n / 3) || busy !== 1'b1) seq_bad++;
      end else if (dut_in !== 3'd7 || busy !== 1'b0) seq_bad++;
      if (n == 5) ps_mid = pass;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = n; ec = err_cnt; fv = fail_vec; ps = pass; end
      end
      start = (n == restart_at - 1);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dut_in !== 3'd0) begin n_bad++; $display("FAIL reset_dut_in got %0d want 0", dut_in); end
    n_cmp++; if ({busy, done, pass} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
    n_cmp++; if (err_cnt !== 4'd0 || fail_vec !== 3'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", err_cnt, fail_vec); end
    n_cmp++; if ({dut_in2, busy2, done2, pass2, err_cnt2, fail_vec2} !== '0) begin n_bad++; $display("FAIL reset_dut2 got %b want 0", {dut_in2, busy2, done2, pass2, err_cnt2, fail_vec2}); end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_sweep(input string name, input logic [7:0] r);
    int lat, nd, sb, eec, efv; logic [3:0] ec; logic [2:0] fv; logic ps, pm;
    resp = r;
    model(EXP, r, 8, eec, efv);
    sweep(0, 3, lat, nd, sb, ec, fv, ps, pm);
    n_cmp++; if (lat != 24 || nd != 1) begin n_bad++; $display("FAIL %s_latency got %0d (%0d pulses) want 24 (1)", name, lat, nd); end
    n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL %s_sequence got %0d bad cycles want 0", name, sb); end
    n_cmp++; if (ec !== 4'(eec)) begin n_bad++; $display("FAIL %s_err_cnt got %0d want %0d", name, ec, eec); end
    n_cmp++; if (fv !== 3'(efv)) begin n_bad++; $display("FAIL %s_fail_vec got %0d want %0d", name, fv, efv); end
    n_cmp++; if (ps !== (eec == 0)) begin n_bad++; $display("FAIL %s_pass got %b want %b", name, ps, eec == 0); end
  endtask

  task automatic test_ideal;
    check_sweep("ideal", EXP);
  endtask

  task automatic test_stuck_one;
    int lat, nd, sb; logic [3:0] ec; logic [2:0] fv; logic ps, pm;
    resp = 8'hFF;
    sweep(0, 2, lat, nd, sb, ec, fv, ps, pm);
    n_cmp++; if (pm !== 1'b1) begin n_bad++; $display("FAIL stuck_pass_held got %b want 1", pm); end
    n_cmp++; if (ec !== 4'd1 || fv !== 3'd7) begin n_bad++; $display("FAIL stuck_counts got %0d/%0d want 1/7", ec, fv); end
    n_cmp++; if (ps !== 1'b0 || lat != 24) begin n_bad++; $display("FAIL stuck_pass got %b@%0d want 0@24", ps, lat); end
  endtask

  task automatic test_and_gate;
    check_sweep("and", ~EXP);
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) check_sweep($sformatf("rand%0d", t), 8'($urandom));
  endtask

  task automatic test_restart_ignored;
    int lat, nd, sb; logic [3:0] ec; logic [2:0] fv; logic ps, pm;
    resp = EXP;
    sweep(10, 40, lat, nd, sb, ec, fv, ps, pm);
    n_cmp++; if (lat != 24 || nd != 1) begin n_bad++; $display("FAIL restart_done got %0d (%0d pulses) want 24 (1)", lat, nd); end
    n_cmp++; if (sb != 0 || ps !== 1'b1) begin n_bad++; $display("FAIL restart_seq got %0d bad / pass %b want 0 / 1", sb, ps); end
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    resp = EXP;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, pass} !== 3'b000 || dut_in !== 3'd0) begin n_bad++; $display("FAIL midrst_outputs got %b/%0d want 000/0", {busy, done, pass}, dut_in); end
    n_cmp++; if (err_cnt !== 4'd0 || fail_vec !== 3'd0) begin n_bad++; $display("FAIL midrst_counts got %0d/%0d want 0/0", err_cnt, fail_vec); end
    repeat (2) begin @(posedge clk); #1 if (done === 1'b1) dn++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1 if (done === 1'b1 || busy === 1'b1) dn++; end
    n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL midrst_quiet got %0d active cycles want 0", dn); end
    check_sweep("after_rst", EXP);
  endtask

  task automatic test_small_back_to_back;
    int lat1 = -1, lat2 = -1;
    resp2 = 4'hF;
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (n == 9) begin
        n_cmp++; if (busy2 !== 1'b1 || err_cnt2 !== 3'd0 || fail_vec2 !== 2'd0 || dut_in2 !== 2'd0) begin
          n_bad++; $display("FAIL small_restart got busy %b err %0d fv %0d in %0d want 1 0 0 0", busy2, err_cnt2, fail_vec2, dut_in2); end
      end
      if (done2 === 1'b1) begin
        if (lat1 < 0) begin
          lat1 = n;
          n_cmp++; if (err_cnt2 !== 3'd1 || fail_vec2 !== 2'd3 || pass2 !== 1'b0) begin
            n_bad++; $display("FAIL small_stuck got %0d/%0d/%b want 1/3/0", err_cnt2, fail_vec2, pass2); end
          start2 = 1'b1;
          resp2  = EXP2;
        end else if (lat2 < 0) begin
          lat2 = n;
          n_cmp++; if (err_cnt2 !== 3'd0 || fail_vec2 !== 2'd0 || pass2 !== 1'b1) begin
            n_bad++; $display("FAIL small_ideal got %0d/%0d/%b want 0/0/1", err_cnt2, fail_vec2, pass2); end
        end
      end
    end
    n_cmp++; if (lat1 != 8 || lat2 != 17) begin n_bad++; $display("FAIL small_latency got %0d,%0d want 8,17", lat1, lat2); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_one();
    test_and_gate();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_small_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
